// File: rtl/button_event_arbiter.sv
// Pushbutton front end: per-channel 2-FF sync, debounce and sticky press latch, round-robin
// arbitrated into one valid/ready event stream. Define BTN_RELEASE_EVT_EN to also emit releases.
module button_event_arbiter #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  localparam int unsigned IW          = $clog2(N_BTN)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] pending,
  output logic             evt_valid,
  output logic [IW-1:0]    evt_id,
  output logic             evt_release,
  input  logic             evt_ready
);

  localparam int unsigned CW  = $clog2(DEBOUNCE_CYC);
`ifdef BTN_RELEASE_EVT_EN
  localparam int unsigned NS  = 2 * N_BTN;
`else
  localparam int unsigned NS  = N_BTN;
`endif
  localparam int unsigned SW  = $clog2(NS);
  localparam int unsigned SW1 = SW + 1;

  localparam logic [CW-1:0]  CntMax   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0]  LastSlot = SW'(NS - 1);
  localparam logic [SW1-1:0] NsW      = SW1'(NS);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  logic [N_BTN-1:0]          sync1_q, sync2_q;
  logic [N_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0]          level_q, level_d, level_prev_q;
  logic [N_BTN-1:0]          pending_q, pending_d, rise;
  logic [NS-1:0]             req, rot, clr;
  logic                      found;
  logic [SW-1:0]             off, pick, cur_slot, ptr_q, ptr_d;
  logic [SW1-1:0]            sum;
  state_e                    state_q, state_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [IW-1:0]             evt_id_q, evt_id_d;
`ifdef BTN_RELEASE_EVT_EN
  localparam logic [SW-1:0]  NBtnS = SW'(N_BTN);
  logic [N_BTN-1:0]          rel_pending_q, rel_pending_d, fall;
  logic                      evt_release_q, evt_release_d;
`endif

  // Debounce: count consecutive cycles the synchronized input disagrees with the level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = level_q & ~level_prev_q;

`ifdef BTN_RELEASE_EVT_EN
  assign fall     = ~level_q & level_prev_q;
  assign req      = {rel_pending_q, pending_q};
  assign cur_slot = SW'(evt_id_q) + (evt_release_q ? NBtnS : '0);
`else
  assign req      = pending_q;
  assign cur_slot = evt_id_q;
`endif

  // Rotate requests so bit 0 is the slot at ptr; lowest set bit is the round-robin winner
  always_comb begin
    rot   = NS'({req, req} >> ptr_q);
    found = |rot;
    off   = '0;
    for (int k = int'(NS) - 1; k >= 0; k--) begin
      if (rot[k]) off = SW'(k);
    end
    sum  = {1'b0, ptr_q} + {1'b0, off};
    pick = (sum >= NsW) ? SW'(sum - NsW) : SW'(sum);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    clr         = '0;
`ifdef BTN_RELEASE_EVT_EN
    evt_release_d = evt_release_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          evt_valid_d = 1'b1;
          state_d     = StOffer;
`ifdef BTN_RELEASE_EVT_EN
          evt_release_d = (pick >= NBtnS);
          evt_id_d      = (pick >= NBtnS) ? IW'(pick - NBtnS) : IW'(pick);
`else
          evt_id_d      = pick;
`endif
        end
      end
      StOffer: begin
        if (evt_ready) begin
          clr[cur_slot] = 1'b1;
          ptr_d         = (cur_slot == LastSlot) ? '0 : cur_slot + 1'b1;
          evt_valid_d   = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new edge and a handshake clear in the same cycle: the new edge wins
  assign pending_d = (pending_q & ~clr[N_BTN-1:0]) | rise;
`ifdef BTN_RELEASE_EVT_EN
  assign rel_pending_d = (rel_pending_q & ~clr[NS-1:N_BTN]) | fall;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      ptr_q        <= '0;
      state_q      <= StIdle;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
`ifdef BTN_RELEASE_EVT_EN
      rel_pending_q <= '0;
      evt_release_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
`ifdef BTN_RELEASE_EVT_EN
      rel_pending_q <= rel_pending_d;
      evt_release_q <= evt_release_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign pending   = pending_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
`ifdef BTN_RELEASE_EVT_EN
  assign evt_release = evt_release_q;
`else
  assign evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter (N_BTN=4, DEBOUNCE_CYC=4) against a cycle-level reference model.
module tb_button_event_arbiter;

  localparam int N   = 4;
  localparam int Deb = 4;
`ifdef BTN_RELEASE_EVT_EN
  localparam bit Rel = 1'b1;
`else
  localparam bit Rel = 1'b0;
`endif
  localparam int Ns = Rel ? 2 * N : N;

  logic       Clk       = 1'b0;
  logic       Reset_n   = 1'b1;
  logic [3:0] btn_raw   = '0;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_level, pending;
  logic       evt_valid, evt_release;
  logic [1:0] evt_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_event_arbiter #(.N_BTN(N), .DEBOUNCE_CYC(Deb)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .pending     (pending),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_release (evt_release),
    .evt_ready   (evt_ready)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [3:0] m_s1, m_s2, m_level, m_pend, m_rpend, m_rise, m_fall;
  int         m_cnt[4];
  logic       m_valid, m_rel;
  logic [1:0] m_id;
  int         m_ptr;

  wire [11:0] dut_vec = {btn_level, pending, evt_valid, evt_id, evt_release};

  function automatic logic [11:0] exp_vec();
    return {m_level, m_pend, m_valid, m_id, m_rel};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_rpend = '0;
    m_rise = '0; m_fall = '0; m_valid = 1'b0; m_rel = 1'b0; m_id = '0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT will see at that edge
  task automatic model_tick();
    logic [3:0] clr_p, clr_r;
    int slot;
    bit hit;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    clr_p = '0; clr_r = '0; hit = 1'b0;
    if (m_valid) begin
      if (evt_ready) begin
        slot = int'(m_id) + (m_rel ? N : 0);
        if (m_rel) clr_r[m_id] = 1'b1;
        else       clr_p[m_id] = 1'b1;
        m_ptr   = (slot + 1) % Ns;
        m_valid = 1'b0;
      end
    end else begin
      for (int k = 0; k < Ns; k++) begin
        slot = (m_ptr + k) % Ns;
        if (!hit && ((slot < N) ? m_pend[slot] : m_rpend[slot - N])) begin
          hit = 1'b1; m_valid = 1'b1; m_id = 2'(slot % N); m_rel = (slot >= N);
        end
      end
    end
    m_pend = (m_pend & ~clr_p) | m_rise;
    if (Rel) m_rpend = (m_rpend & ~clr_r) | m_fall;
    for (int i = 0; i < N; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (m_s2[i] == m_level[i]) m_cnt[i] = 0;
      else if (m_cnt[i] < Deb - 1) m_cnt[i]++;
      else begin
        m_level[i] = m_s2[i];
        m_cnt[i]   = 0;
        if (m_s2[i]) m_rise[i] = 1'b1;
        else         m_fall[i] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask

  task automatic step();
    model_tick();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
  endtask

  function automatic bit quiet();
    bit q;
    q = (m_s1 == btn_raw) && (m_s2 == btn_raw) && (m_level == btn_raw) && (m_pend == 0) &&
        (m_rpend == 0) && !m_valid && (m_rise == 0) && (m_fall == 0);
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic settle(output bit ok);
    evt_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (quiet()) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    model_reset();
    step();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge Clk);
    btn_raw = 4'hF; evt_ready = 1'b1; Reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec !== 12'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=000", dut_vec);
    end
    @(negedge Clk);
    step();
    Reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL reset_model c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
      if (c == 5 || c == 6) begin
        total++;
        if (btn_level !== ((c == 6) ? 4'hF : 4'h0)) begin
          bad++; $display("FAIL reset_latency c=%0d got=%h want=%h", c, btn_level,
                          (c == 6) ? 4'hF : 4'h0);
        end
      end
    end
    btn_raw = 4'h0;
    settle(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL reset_settle got=timeout want=quiet");
    end
  endtask

  task automatic test_press();
    bit ok;
    btn_raw = 4'b0010; evt_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL press_model c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
      case (c)
        5: begin
          total++;
          if (btn_level[1] !== 1'b0) begin
            bad++; $display("FAIL press_lvl5 got=%b want=0", btn_level[1]);
          end
        end
        6: begin
          total++;
          if (btn_level[1] !== 1'b1 || pending[1] !== 1'b0) begin
            bad++; $display("FAIL press_lvl6 got=%b%b want=10", btn_level[1], pending[1]);
          end
        end
        7: begin
          total++;
          if (pending[1] !== 1'b1 || evt_valid !== 1'b0) begin
            bad++; $display("FAIL press_pend7 got=%b%b want=10", pending[1], evt_valid);
          end
        end
        8: begin
          total++;
          if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b0) begin
            bad++; $display("FAIL press_evt8 got=%b/%0d/%b want=1/1/0", evt_valid, evt_id,
                            evt_release);
          end
        end
        9: begin
          total++;
          if (pending[1] !== 1'b0 || evt_valid !== 1'b0) begin
            bad++; $display("FAIL press_clr9 got=%b%b want=00", pending[1], evt_valid);
          end
        end
        default: ;
      endcase
    end
    btn_raw = 4'h0;
    settle(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL press_settle got=timeout want=quiet");
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 14; c++) begin
      btn_raw = (c < 3) ? 4'b0100 : 4'b0000;
      step();
      total++;
      if ({btn_level, pending, evt_valid} !== 9'h0 || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bounce c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic b2b_round(input logic [3:0] raw, input int n_exp, input logic [5:0] exp_ids);
    logic [1:0] ids[$];
    logic prev_v;
    bit ok;
    prev_v = 1'b0;
    btn_raw = raw; evt_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL b2b_model c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
      if (evt_valid) begin
        total++;
        if (prev_v !== 1'b0) begin
          bad++; $display("FAIL b2b_bubble c=%0d got=valid twice want=gap", c);
        end
        if (!evt_release) ids.push_back(evt_id);
      end
      prev_v = evt_valid;
    end
    total++;
    if (ids.size() != n_exp ||
        (n_exp == 3 && (ids[0] !== exp_ids[5:4] || ids[1] !== exp_ids[3:2] ||
                        ids[2] !== exp_ids[1:0])) ||
        (n_exp == 2 && (ids[0] !== exp_ids[3:2] || ids[1] !== exp_ids[1:0]))) begin
      bad++; $display("FAIL b2b_order got=%p want=%h(n=%0d)", ids, exp_ids, n_exp);
    end
    btn_raw = 4'h0;
    settle(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_settle got=timeout want=quiet");
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    b2b_round(4'b1101, 3, {2'd0, 2'd2, 2'd3});
    b2b_round(4'b1001, 2, {2'd0, 2'd0, 2'd3});
  endtask

  task automatic test_stall();
    logic [1:0] ids[$];
    bit seen, ok;
    btn_raw = 4'b0001; evt_ready = 1'b0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL stall_wait c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
      seen = evt_valid;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stall_offer got=no_offer want=offer");
    end
    for (int c = 0; c < 40; c++) begin
      btn_raw = {2'b00, c >= 5, (c < 10) || (c >= 20)};
      step();
      total++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_release !== 1'b0 ||
          dut_vec !== exp_vec()) begin
        bad++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (evt_valid && !evt_release) ids.push_back(evt_id);
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL stall_drain c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    total++;
    if (ids.size() != 2 || ids[0] !== 2'd0 || ids[1] !== 2'd1) begin
      bad++; $display("FAIL stall_order got=%p want=0,1", ids);
    end
    btn_raw = 4'h0;
    settle(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL stall_settle got=timeout want=quiet");
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    btn_raw = 4'h0;
    settle(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL random_settle got=timeout want=quiet");
    end
  endtask

  task automatic test_reset_mid_offer();
    bit seen;
    btn_raw = 4'b0010; evt_ready = 1'b0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      seen = evt_valid;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rst_offer got=no_offer want=offer");
    end
    btn_raw = 4'h0;
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (evt_valid !== 1'b0 || pending !== 4'h0 || btn_level !== 4'h0) begin
      bad++; $display("FAIL rst_async got=%h want=000", dut_vec);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    evt_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if (evt_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL rst_after c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

`ifdef BTN_RELEASE_EVT_EN
  task automatic test_release();
    logic [2:0] evs[$];
    btn_raw = 4'b1000; evt_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 15) btn_raw = 4'h0;
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL release_model c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
      if (evt_valid) evs.push_back({evt_release, evt_id});
    end
    total++;
    if (evs.size() != 2 || evs[0] !== 3'b011 || evs[1] !== 3'b111) begin
      bad++; $display("FAIL release_order got=%p want=3,7", evs);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_press();
    test_bounce();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid_offer();
`ifdef BTN_RELEASE_EVT_EN
    test_release();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
